// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the stopwatch datapath.
// Turns button edges, adjust-mode requests and the 2 Hz strobe into
// registered single-cycle command pulses (sec_inc, adj_sec_inc, min_inc,
// clr) plus the running/adjusting status and the display blink enable.
// It holds no time value; the minute/second counter lives downstream.
module stopwatch_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       reset_btn,
    input  logic       sel,
    input  logic [1:0] adj,
    output logic       sec_inc,
    output logic       adj_sec_inc,
    output logic       min_inc,
    output logic       clr,
    output logic       running,
    output logic       adjusting,
    output logic       blink
);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    state_t state, state_nxt;

    // phase tracks the sub-second half of the 1 Hz cadence built from 2 Hz ticks
    logic phase, phase_nxt;
    logic blink_nxt;
    logic sec_inc_nxt, adj_sec_inc_nxt, min_inc_nxt, clr_nxt;

    // Previous button levels reset to 1 so a button held through reset
    // produces no edge until it is released and pressed again.
    logic pause_prev, reset_prev;
    logic pause_edge, reset_edge;

    assign pause_edge = pause_btn & ~pause_prev;
    assign reset_edge = reset_btn & ~reset_prev;

    // Next-state and next-output decode, highest-priority event first
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt       = state;
        phase_nxt       = phase;
        blink_nxt       = blink;
        sec_inc_nxt     = 1'b0;
        adj_sec_inc_nxt = 1'b0;
        min_inc_nxt     = 1'b0;
        clr_nxt         = 1'b0;

        if (reset_edge) begin
            // User clear wins the cycle: ticks and pause edges are dropped
            clr_nxt   = 1'b1;
            phase_nxt = 1'b0;
            if (state == RUN) begin
                state_nxt = PAUSED;
            end
        end else if ((adj != 2'b00) && (state != ADJUST)) begin
            // Entering adjust restarts the blink and the sub-second phase
            state_nxt = ADJUST;
            phase_nxt = 1'b0;
            blink_nxt = 1'b1;
        end else if ((adj == 2'b00) && (state == ADJUST)) begin
            state_nxt = PAUSED;
            blink_nxt = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (pause_edge) begin
                        state_nxt = PAUSED;
                    end else if (tick_2hz) begin
                        phase_nxt   = ~phase;
                        sec_inc_nxt = phase;
                    end
                end
                PAUSED: begin
                    // Ticks ignored and phase held so resume keeps its position
                    if (pause_edge) begin
                        state_nxt = RUN;
                    end
                end
                ADJUST: begin
                    if (tick_2hz) begin
                        blink_nxt       = ~blink;
                        adj_sec_inc_nxt = sel;
                        min_inc_nxt     = ~sel;
                    end
                end
                default: begin
                    state_nxt = PAUSED;
                end
            endcase
        end

        // The display field is always lit outside adjust mode
        if (state_nxt != ADJUST) begin
            blink_nxt = 1'b1;
        end
    end

    // State, phase, edge history and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PAUSED;
            phase       <= 1'b0;
            blink       <= 1'b1;
            sec_inc     <= 1'b0;
            adj_sec_inc <= 1'b0;
            min_inc     <= 1'b0;
            clr         <= 1'b0;
            running     <= 1'b0;
            adjusting   <= 1'b0;
            pause_prev  <= 1'b1;
            reset_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state       <= state_nxt;
            phase       <= phase_nxt;
            blink       <= blink_nxt;
            sec_inc     <= sec_inc_nxt;
            adj_sec_inc <= adj_sec_inc_nxt;
            min_inc     <= min_inc_nxt;
            clr         <= clr_nxt;
            running     <= (state_nxt == RUN);
            adjusting   <= (state_nxt == ADJUST);
            pause_prev  <= pause_btn;
            reset_prev  <= reset_btn;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scenario-driven bench for stopwatch_ctrl.
// Each stimulus row is {pause_btn, reset_btn, tick_2hz, sel, adj[1:0],
// expected {sec_inc, adj_sec_inc, min_inc, clr, running, adjusting, blink}}.
// The expected vector is queued when the row is driven and popped for
// comparison once the DUT has registered its response one edge later.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       reset;
    logic       tick_2hz;
    logic       pause_btn;
    logic       reset_btn;
    logic       sel;
    logic [1:0] adj;
    logic       sec_inc;
    logic       adj_sec_inc;
    logic       min_inc;
    logic       clr;
    logic       running;
    logic       adjusting;
    logic       blink;

    logic [6:0] exp_q[$];
    int         n_vec;
    int         n_err;

    localparam logic [6:0] RESET_OUT = 7'b0000_001;

    stopwatch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick_2hz   (tick_2hz),
        .pause_btn  (pause_btn),
        .reset_btn  (reset_btn),
        .sel        (sel),
        .adj        (adj),
        .sec_inc    (sec_inc),
        .adj_sec_inc(adj_sec_inc),
        .min_inc    (min_inc),
        .clr        (clr),
        .running    (running),
        .adjusting  (adjusting),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dut_out();
        return {sec_inc, adj_sec_inc, min_inc, clr, running, adjusting, blink};
    endfunction

    // Apply one row of inputs, queue its expectation, advance past the edge
    task automatic drive(input logic [12:0] row);
        pause_btn = row[12];
        reset_btn = row[11];
        tick_2hz  = row[10];
        sel       = row[9];
        adj       = row[8:7];
        exp_q.push_back(row[6:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        reset     = 1'b1;
        pause_btn = 1'b0;
        reset_btn = 1'b0;
        tick_2hz  = 1'b0;
        sel       = 1'b0;
        adj       = 2'b00;
        exp_q.push_back(RESET_OUT);
        #12;
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out() !== e) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", dut_out(), e);
        end
        reset = 1'b0;
    endtask

    task automatic test_run();
        logic [12:0] tbl [11];
        logic [6:0]  e;
        tbl = '{
            13'b0_0_0_0_00_0000_001,  // idle: prev regs capture released buttons
            13'b1_0_0_0_00_0000_101,  // pause edge -> RUN
            13'b1_0_0_0_00_0000_101,  // held button: no second edge
            13'b0_0_0_0_00_0000_101,
            13'b0_0_1_0_00_0000_101,  // tick 1: phase 0->1
            13'b0_0_0_0_00_0000_101,
            13'b0_0_1_0_00_1000_101,  // tick 2: sec_inc
            13'b0_0_0_0_00_0000_101,  // pulse is one cycle wide
            13'b0_0_1_0_00_0000_101,  // tick 3
            13'b0_0_1_0_00_1000_101,  // tick 4 back-to-back: sec_inc
            13'b0_0_1_0_00_0000_101   // tick 5: leave phase = 1
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out() !== e) begin
                n_err++;
                $display("FAIL run[%0d]: got %b expected %b", i, dut_out(), e);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic [12:0] tbl [9];
        logic [6:0]  e;
        tbl = '{
            13'b1_0_0_0_00_0000_001,  // pause edge -> PAUSED
            13'b0_0_0_0_00_0000_001,
            13'b0_0_1_0_00_0000_001,  // ticks ignored
            13'b0_0_0_0_00_0000_001,
            13'b0_0_1_0_00_0000_001,
            13'b0_0_1_0_00_0000_001,
            13'b1_0_0_0_00_0000_101,  // resume with phase = 1
            13'b0_0_1_0_00_1000_101,  // first tick after resume: sec_inc
            13'b0_0_0_0_00_0000_101
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out() !== e) begin
                n_err++;
                $display("FAIL pause_resume[%0d]: got %b expected %b", i, dut_out(), e);
            end
        end
    endtask

    task automatic test_adjust();
        logic [12:0] tbl [10];
        logic [6:0]  e;
        tbl = '{
            13'b0_0_1_0_01_0000_011,  // enter ADJUST, tick in entry cycle ignored
            13'b0_0_1_0_01_0010_010,  // min_inc, blink 0
            13'b0_0_0_0_01_0000_010,
            13'b0_0_1_0_01_0010_011,  // min_inc, blink 1
            13'b0_0_1_0_01_0010_010,  // min_inc, blink 0
            13'b0_0_1_1_01_0100_011,  // sel = 1: adj_sec_inc, blink 1
            13'b0_0_1_1_01_0100_010,  // adj_sec_inc, blink 0
            13'b1_0_0_0_01_0000_010,  // pause edge ignored in ADJUST
            13'b0_0_0_0_01_0000_010,
            13'b0_0_0_0_00_0000_001   // adj = 0 -> PAUSED, blink forced 1
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out() !== e) begin
                n_err++;
                $display("FAIL adjust[%0d]: got %b expected %b", i, dut_out(), e);
            end
        end
    endtask

    task automatic test_clear_collision();
        logic [12:0] tbl [9];
        logic [6:0]  e;
        tbl = '{
            13'b1_0_0_0_00_0000_101,  // -> RUN, phase 0
            13'b0_0_1_0_00_0000_101,  // phase -> 1
            13'b1_1_1_0_00_0001_001,  // clear + pause + tick: clr only, PAUSED
            13'b1_1_0_0_00_0000_001,  // held buttons: no repeat
            13'b0_0_0_0_00_0000_001,
            13'b1_0_0_0_00_0000_101,  // resume
            13'b0_0_1_0_00_0000_101,  // phase was cleared: no pulse yet
            13'b0_0_1_0_00_1000_101,
            13'b0_0_0_0_00_0000_101
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out() !== e) begin
                n_err++;
                $display("FAIL clear_collision[%0d]: got %b expected %b", i, dut_out(), e);
            end
        end
    endtask

    task automatic test_held_clear_through_reset();
        logic [12:0] tbl [6];
        logic [6:0]  e;
        reset_btn = 1'b1;
        reset     = 1'b1;
        exp_q.push_back(RESET_OUT);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out() !== e) begin
            n_err++;
            $display("FAIL held_reset_assert: got %b expected %b", dut_out(), e);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        tbl = '{
            13'b0_1_0_0_00_0000_001,  // button held through reset: no clr
            13'b0_1_0_0_00_0000_001,
            13'b0_0_0_0_00_0000_001,  // release
            13'b0_1_0_0_00_0001_001,  // fresh press: one clr
            13'b0_1_0_0_00_0000_001,
            13'b0_0_0_0_00_0000_001
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out() !== e) begin
                n_err++;
                $display("FAIL held_clear[%0d]: got %b expected %b", i, dut_out(), e);
            end
        end
    endtask

    task automatic test_async_mid_pulse();
        logic [12:0] tbl [3];
        logic [6:0]  e;
        tbl = '{
            13'b1_0_0_0_00_0000_101,  // -> RUN
            13'b0_0_1_0_00_0000_101,
            13'b0_0_1_0_00_1000_101   // sec_inc high now
        };
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out() !== e) begin
                n_err++;
                $display("FAIL async_setup[%0d]: got %b expected %b", i, dut_out(), e);
            end
        end
        // Assert reset between edges while sec_inc is high
        reset = 1'b1;
        exp_q.push_back(RESET_OUT);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out() !== e) begin
            n_err++;
            $display("FAIL async_mid_pulse: got %b expected %b", dut_out(), e);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(13'b0_0_0_0_00_0000_001);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out() !== e) begin
            n_err++;
            $display("FAIL async_after_release: got %b expected %b", dut_out(), e);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_run();
        test_pause_resume();
        test_adjust();
        test_clear_collision();
        test_held_clear_through_reset();
        test_async_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
